// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared constants, types and BCD helper for the time display
package clock_pkg;

    localparam int NUM_DIGITS = 6;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [5:0] MAX_SEC  = 6'd59;
    localparam logic [5:0] MAX_MIN  = 6'd59;
    localparam logic [4:0] MAX_HOUR = 5'd23;

    typedef enum logic [1:0] {
        SOLID,
        BLINK_ON,
        BLINK_OFF
    } blink_state_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    // Compare/subtract split of a 6-bit value into tens/ones (valid for 0..63)
    function automatic bcd_t bcd_split(input logic [5:0] v);
        bcd_t       res;
        logic [5:0] r;
        logic [3:0] t;
        r = v;
        t = 4'd0;
        if (r >= 6'd40) begin
            r = r - 6'd40;
            t = t + 4'd4;
        end
        if (r >= 6'd20) begin
            r = r - 6'd20;
            t = t + 4'd2;
        end
        if (r >= 6'd10) begin
            r = r - 6'd10;
            t = t + 4'd1;
        end
        res.tens = t;
        res.ones = r[3:0];
        return res;
    endfunction

endpackage

// File: rtl/clock_time_display_if.sv
// rtl/clock_time_display_if.sv - time inputs and 7-segment outputs bundle
interface clock_time_display_if;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       alarm;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output sec, min, hour, alarm,
        input  an, seg, dp
    );

    modport slave (
        input  sec, min, hour, alarm,
        output an, seg, dp
    );
endinterface

// File: rtl/clock_time_display_seg7_decode.sv
// rtl/clock_time_display_seg7_decode.sv - BCD digit or dash to active-low segment pattern
module seg7_decode
    import clock_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (dash) begin
            seg = SEG_DASH;
        end else begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/clock_time_display.sv
// rtl/clock_time_display.sv - multiplexed HH.MM.SS 7-segment driver with frame snapshot and alarm blink
module clock_time_display
    import clock_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    clock_time_display_if.slave  bus
);

    localparam int PW = $clog2(SCAN_DIV + 1);
    localparam int CW = $clog2(BLINK_FRAMES + 1);

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic [5:0]    snap_sec;
    logic [5:0]    snap_min;
    logic [4:0]    snap_hour;
    logic          terminal;
    logic          frame_wrap;

    assign terminal   = (presc == PW'(SCAN_DIV - 1));
    assign frame_wrap = terminal && (idx == 3'd5);

    // Time is only captured at the frame boundary so a frame never mixes old and new digits
    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            idx       <= 3'd0;
            snap_sec  <= 6'd0;
            snap_min  <= 6'd0;
            snap_hour <= 5'd0;
        end else begin
            presc <= terminal ? '0 : presc + 1'b1;
            if (terminal) begin
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end
            if (frame_wrap) begin
                snap_sec  <= bus.sec;
                snap_min  <= bus.min;
                snap_hour <= bus.hour;
            end
        end
    end

    blink_state_t  state;
    blink_state_t  state_next;
    logic [CW-1:0] blink_cnt;
    logic [CW-1:0] blink_cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SOLID;
            blink_cnt <= '0;
        end else begin
            state     <= state_next;
            blink_cnt <= blink_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        blink_cnt_next = blink_cnt;
        if (!bus.alarm) begin
            state_next     = SOLID;
            blink_cnt_next = '0;
        end else begin
            if (state == SOLID) begin
                state_next = BLINK_ON;
            end
            if (frame_wrap) begin
                if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
                    blink_cnt_next = '0;
                    state_next     = (state == BLINK_OFF) ? BLINK_ON : BLINK_OFF;
                end else begin
                    blink_cnt_next = blink_cnt + 1'b1;
                end
            end
        end
    end

    bcd_t sec_bcd;
    bcd_t min_bcd;
    bcd_t hour_bcd;
    logic sec_bad;
    logic min_bad;
    logic hour_bad;
    logic [3:0] digit;
    logic       dash;
    logic [6:0] dec_seg;

    assign sec_bcd  = bcd_split(snap_sec);
    assign min_bcd  = bcd_split(snap_min);
    assign hour_bcd = bcd_split({1'b0, snap_hour});
    assign sec_bad  = (snap_sec > MAX_SEC);
    assign min_bad  = (snap_min > MAX_MIN);
    assign hour_bad = (snap_hour > MAX_HOUR);

    always_comb begin
        digit = 4'd0;
        dash  = 1'b0;
        case (idx)
            3'd0: begin digit = sec_bcd.ones;  dash = sec_bad;  end
            3'd1: begin digit = sec_bcd.tens;  dash = sec_bad;  end
            3'd2: begin digit = min_bcd.ones;  dash = min_bad;  end
            3'd3: begin digit = min_bcd.tens;  dash = min_bad;  end
            3'd4: begin digit = hour_bcd.ones; dash = hour_bad; end
            3'd5: begin digit = hour_bcd.tens; dash = hour_bad; end
            default: begin digit = 4'd0; dash = 1'b0; end
        endcase
    end

    seg7_decode u_decode (
        .bcd  (digit),
        .dash (dash),
        .seg  (dec_seg)
    );

    logic [5:0] an_r;
    logic [6:0] seg_r;
    logic       dp_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            an_r  <= 6'h3F;
            seg_r <= SEG_OFF;
            dp_r  <= 1'b1;
        end else if ((presc < PW'(BLANK_CYC)) || (state == BLINK_OFF)) begin
            an_r  <= 6'h3F;
            seg_r <= SEG_OFF;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= ~(6'd1 << idx);
            seg_r <= dec_seg;
            dp_r  <= !((idx == 3'd2) || (idx == 3'd4));
        end
    end

    assign bus.an  = an_r;
    assign bus.seg = seg_r;
    assign bus.dp  = dp_r;

endmodule

// File: tb/tb_clock_time_display.sv
// tb/tb_clock_time_display.sv - scoreboard bench with frame-level reference model for clock_time_display
module tb_clock_time_display;

    localparam int SCAN_DIV     = 4;
    localparam int BLANK_CYC    = 1;
    localparam int BLINK_FRAMES = 2;
    localparam int NDIG         = 6;
    localparam int FRAME        = SCAN_DIV * NDIG;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clock_time_display_if bus ();

    clock_time_display #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYC    (BLANK_CYC),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        int         tag;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Model state: edges since reset, frames since alarm rose, time shown this frame
    int kk  = 0;
    int afr = 0;
    int m_sec  = 0;
    int m_min  = 0;
    int m_hour = 0;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic exp_t expect_digit(input int i);
        exp_t e;
        int   v;
        int   lim;
        v   = (i < 2) ? m_sec : (i < 4) ? m_min : m_hour;
        lim = (i < 4) ? 59 : 23;
        e.an  = 6'h3F ^ (6'd1 << i);
        e.seg = (v > lim) ? 7'b0111111 : seg_of((i % 2 == 0) ? v % 10 : v / 10);
        e.dp  = (i == 2 || i == 4) ? 1'b0 : 1'b1;
        e.tag = 0;
        return e;
    endfunction

    // Reference model: after each edge, predict the output of the following edge
    initial begin
        exp_t e;
        int   p;
        int   i;
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                kk = 0; afr = 0;
                m_sec = 0; m_min = 0; m_hour = 0;
            end else begin
                if (!bus.alarm) afr = 0;
                if ((kk + 1) % FRAME == 0) begin
                    m_sec  = int'(bus.sec);
                    m_min  = int'(bus.min);
                    m_hour = int'(bus.hour);
                    if (bus.alarm) afr = afr + 1;
                end
                p = (kk + 1) % SCAN_DIV;
                i = ((kk + 1) / SCAN_DIV) % NDIG;
                if (p >= BLANK_CYC && ((afr / BLINK_FRAMES) % 2) == 0) begin
                    e     = expect_digit(i);
                    e.tag = kk + 1;
                    q.push_back(e);
                end
                kk = kk + 1;
            end
        end
    end

    // Monitor: each negedge either a predicted digit or a dark display
    initial begin
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            checks = checks + 1;
            if (q.size() > 0 && q[0].tag == kk - 1) begin
                e = q.pop_front();
                if (bus.an !== e.an || bus.seg !== e.seg || bus.dp !== e.dp) begin
                    errors = errors + 1;
                    $display("FAIL digit edge=%0d got an=%b seg=%b dp=%b required an=%b seg=%b dp=%b",
                             e.tag, bus.an, bus.seg, bus.dp, e.an, e.seg, e.dp);
                end
            end else if (bus.an !== 6'h3F) begin
                errors = errors + 1;
                $display("FAIL dark edge=%0d got an=%b required an=111111", kk - 1, bus.an);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        bus.hour = 5'(h);
        bus.min  = 6'(m);
        bus.sec  = 6'(s);
    endtask

    initial begin
        bus.alarm = 1'b0;
        set_time(12, 34, 56);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;

        // Steady 12:34:56 scan
        tick(3 * FRAME);

        // Seconds change mid-frame while digit 2 is being scanned
        while ((kk / SCAN_DIV) % NDIG != 2) tick(1);
        bus.sec = 6'd57;
        tick(2 * FRAME);

        // Out-of-range seconds only
        set_time(23, 7, 60);
        tick(2 * FRAME);

        // Mid-frame reset held three edges
        tick(7);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks = checks + 1;
        if (bus.an !== 6'h3F || bus.seg !== 7'h7F || bus.dp !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL reset got an=%b seg=%b dp=%b required an=111111 seg=1111111 dp=1",
                     bus.an, bus.seg, bus.dp);
        end
        tick(2);
        rst = 1'b0;
        tick(2 * FRAME);

        // Rollover applied mid-frame
        set_time(23, 59, 59);
        tick(FRAME + 5);
        set_time(0, 0, 0);
        tick(2 * FRAME);

        // Alarm blink, then drop during a dark frame
        set_time(1, 2, 3);
        bus.alarm = 1'b1;
        tick(9 * FRAME);
        while (((afr / BLINK_FRAMES) % 2) == 0) tick(1);
        tick(5);
        bus.alarm = 1'b0;
        tick(2 * FRAME);

        // Randomized time values, alarm toggles and change points
        for (int n = 0; n < 40; n++) begin
            set_time($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
            if ($urandom_range(0, 4) == 0) bus.alarm = ~bus.alarm;
            tick($urandom_range(1, 2 * FRAME));
        end
        bus.alarm = 1'b0;
        tick(2 * FRAME);

        @(negedge clk);
        #1;
        checks = checks + 1;
        if (q.size() > 1) begin
            errors = errors + 1;
            $display("FAIL drain got pending=%0d required pending<=1", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
